// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: sits between the MEM stage and the byte-wide data segment.
// It splits 16-bit loads and stores into two byte transactions and assembles
// load data little-endian. It rejects misaligned and out-of-segment accesses.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for req; inputs latched and checked on accept
// B0    | byte 0 address on the port (write strobe for stores)
// B1    | byte 1 address on the port; load byte 0 captured from mem_rd
// R1    | no port drive; last load byte captured from mem_rd
// FIN   | done pulse (err valid); always returns to IDLE
module data_mem_ctrl #(
  parameter int WIDTH     = 16,
  parameter int ADDRWIDTH = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             wr,
  input  logic             word,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_a,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  typedef enum logic [2:0] {IDLE, B0, B1, R1, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] wd_q;
  logic             wr_q;
  logic             word_q;
  logic             bad;
  logic             unused_rd_hi;

  // Only the low byte of the segment read port carries data.
  assign unused_rd_hi = ^mem_rd[WIDTH-1:8];

  // Reject misaligned words and any address above the data segment.
  assign bad = (word & addr[0]) | (|addr[WIDTH-1:ADDRWIDTH]);

  // The stall is cleared in the done cycle, so the stage advances exactly then.
  assign busy = ~reset & req & ~done;

  // Sequencer: state, latched request and registered results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_q    <= '0;
      wd_q   <= '0;
      wr_q   <= 1'b0;
      word_q <= 1'b0;
      rdata  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            a_q    <= addr;
            wd_q   <= wdata;
            wr_q   <= wr;
            word_q <= word;
            if (bad) begin
              state <= FIN;
              done  <= 1'b1;
              err   <= 1'b1;
              rdata <= '0;
            end else begin
              state <= B0;
            end
          end
        end
        B0: begin
          if (word_q) begin
            state <= B1;
          end else if (wr_q) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            state <= R1;
          end
        end
        B1: begin
          if (wr_q) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            rdata[7:0] <= mem_rd[7:0];
            state      <= R1;
          end
        end
        R1: begin
          if (word_q) rdata[15:8] <= mem_rd[7:0];
          else        rdata       <= {{(WIDTH-8){1'b0}}, mem_rd[7:0]};
          state <= FIN;
          done  <= 1'b1;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Segment port is decoded straight from state so reset drops mem_we at once.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    case (state)
      B0: begin
        mem_a = a_q;
        if (wr_q) begin
          mem_we = 1'b1;
          mem_wd = {{(WIDTH-8){1'b0}}, wd_q[7:0]};
        end
      end
      B1: begin
        mem_a = a_q + WIDTH'(1);
        if (wr_q) begin
          mem_we = 1'b1;
          mem_wd = {{(WIDTH-8){1'b0}}, wd_q[15:8]};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a byte-wide synchronous-read memory model.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr, word;
  logic [15:0] addr, wdata;
  logic [15:0] rdata, mem_a, mem_wd, mem_rd;
  logic        done, err, busy, mem_we;

  logic [7:0]  mem [0:8191];
  logic [31:0] wq [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  data_mem_ctrl #(.WIDTH(16), .ADDRWIDTH(13)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .word(word),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
    .busy(busy), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Data segment model: write on the edge, read data one cycle after the address.
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[12:0]] <= mem_wd[7:0];
    mem_rd <= {8'h00, mem[mem_a[12:0]]};
  end

  // Log every write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (mem_we && !reset) wq.push_back({mem_a, mem_wd});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one access from IDLE (#1 after an edge) and returns in IDLE.
  task automatic run(input string tag, input logic w, input logic wd,
                     input logic [15:0] a, input logic [15:0] d,
                     input int lat, input logic e, input logic [15:0] exp_rd);
    int lat_seen;
    int we_cnt;
    lat_seen = 99;
    we_cnt   = 0;
    req = 1'b1; wr = w; word = wd; addr = a; wdata = d;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      #1;
      if (k == 0) addr = 16'hFFFF;   // must be ignored after accept
      if (mem_we) we_cnt++;
      if (done) begin
        lat_seen = k + 1;
        break;
      end
      @(posedge clk);
    end
    check({tag, " latency"}, lat_seen, lat);
    check({tag, " err"}, {31'd0, err}, {31'd0, e});
    check({tag, " rdata"}, {16'd0, rdata}, {16'd0, exp_rd});
    check({tag, " we cycles"}, we_cnt, e ? 0 : (w ? (wd ? 2 : 1) : 0));
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [7:0] snap21;
  logic [1:0] exp_done [0:7];

  initial begin
    reset = 1'b1; req = 1'b1; wr = 1'b0; word = 1'b0; addr = '0; wdata = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset outputs", {rdata, mem_a}, 32'd0);
    check("reset flags", {26'd0, done, err, busy, mem_we, mem_wd[0], |mem_wd}, 32'd0);
    req = 1'b0; reset = 1'b0;
    @(posedge clk); #1;

    wq.delete();
    run("st word 0010", 1, 1, 16'h0010, 16'hBEEF, 3, 0, 16'h0000);
    check("st word writes", wq.size(), 2);
    if (wq.size() == 2) begin
      check("st word wr0", wq[0], 32'h0010_00EF);
      check("st word wr1", wq[1], 32'h0011_00BE);
    end
    run("ld word 0010", 0, 1, 16'h0010, 16'h0000, 4, 0, 16'hBEEF);
    run("st byte 1fff", 1, 0, 16'h1FFF, 16'h995A, 2, 0, 16'hBEEF);
    run("ld byte 1fff", 0, 0, 16'h1FFF, 16'h0000, 3, 0, 16'h005A);
    wq.delete();
    run("ld word misalign", 0, 1, 16'h0011, 16'h0000, 1, 1, 16'h0000);
    run("st word misalign", 1, 1, 16'h0011, 16'h1111, 1, 1, 16'h0000);
    run("ld byte 2000", 0, 0, 16'h2000, 16'h0000, 1, 1, 16'h0000);
    check("errors no writes", wq.size(), 0);

    // Back-to-back loads with req held high.
    run("st byte 0004", 1, 0, 16'h0004, 16'h0077, 2, 0, 16'h0000);
    run("st word 0006", 1, 1, 16'h0006, 16'hC3D2, 3, 0, 16'h0000);
    exp_done[0] = 2'b01; exp_done[1] = 2'b01; exp_done[2] = 2'b10;
    exp_done[3] = 2'b01; exp_done[4] = 2'b01; exp_done[5] = 2'b01;
    exp_done[6] = 2'b01; exp_done[7] = 2'b10;
    req = 1'b1; wr = 1'b0; word = 1'b0; addr = 16'h0004;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("b2b done/busy k%0d", k), {30'd0, done, busy}, {30'd0, exp_done[k]});
      if (k == 0 || k == 5) addr = 16'h0100;
      if (k == 2) begin
        check("b2b byte rdata", rdata, 16'h0077);
        addr = 16'h0006; word = 1'b1;
      end
      if (k == 7) check("b2b word rdata", rdata, 16'hC3D2);
      @(posedge clk);
    end
    #1; req = 1'b0;
    @(posedge clk); #1;

    // Reset during B1 of a word store.
    snap21 = mem[13'h0021];
    req = 1'b1; wr = 1'b1; word = 1'b1; addr = 16'h0020; wdata = 16'h1234;
    @(posedge clk); @(posedge clk); #1;
    check("B1 strobe", {mem_we, mem_a}, {1'b1, 16'h0021});
    reset = 1'b1;
    #1;
    check("mid reset outputs", {rdata, mem_a}, 32'd0);
    check("mid reset flags", {26'd0, done, err, busy, mem_we, |mem_wd, 1'b0}, 32'd0);
    req = 1'b0;
    @(posedge clk); #1;
    check("mid reset no done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mem 0020", mem[13'h0020], 32'h34);
    check("mem 0021", mem[13'h0021], {24'd0, snap21});
    run("ld word after rst", 0, 1, 16'h0020, 16'h0000, 4, 0, {snap21, 8'h34});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-side access controller that sits between the pipeline MEM stage and the data-segment port of the segmented memory. The data segment is byte-wide with synchronous read, so the controller splits 16-bit loads and stores into two byte transactions, assembles little-endian load data, and stalls the pipeline until each access completes. It also rejects misaligned and out-of-segment accesses.

## Interface
- WIDTH, 16, datapath and address width
- ADDRWIDTH, 13, byte-address bits of the data segment; higher address bits must be zero

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- req  in  1  access request from MEM stage, level, held until `done`
- wr  in  1  1 = store, 0 = load; sampled with `req` in IDLE
- word  in  1  1 = 16-bit access, 0 = byte access; sampled with `req` in IDLE
- addr  in  WIDTH  byte address; sampled with `req` in IDLE
- wdata  in  WIDTH  store data; sampled with `req` in IDLE
- rdata  out  WIDTH  load result, registered
- done  out  1  one-cycle completion pulse, registered
- err  out  1  valid with `done`: access rejected
- busy  out  1  pipeline stall, combinational
- mem_we  out  1  data-segment write enable
- mem_a  out  WIDTH  data-segment byte address
- mem_wd  out  WIDTH  data-segment write data, bits [15:8] always 0
- mem_rd  in  WIDTH  data-segment read data, only [7:0] meaningful, valid the cycle after the address is presented

## Operation
- States: IDLE, B0, B1, R1, FIN.
- IDLE with req=1 latches addr, wdata, wr and word. Inputs are ignored until the next IDLE.
- Error check in IDLE:
  - word=1 with addr[0]=1 is misaligned.
  - Any addr[WIDTH-1:ADDRWIDTH] bit set is out of segment.
  - On error: go to FIN with err=1, no mem_we, rdata forced to 0.
- B0 drives mem_a = latched addr.
  - Store: mem_we=1, mem_wd={8'b0, wdata[7:0]}.
  - Next state: B1 if word, else FIN for a store, else R1 for a load.
- B1 drives mem_a = addr+1.
  - Store: mem_we=1, mem_wd={8'b0, wdata[15:8]}.
  - Load: captures mem_rd[7:0] (byte 0) into rdata[7:0].
  - Next state: FIN for a store, R1 for a load.
- R1: no memory drive.
  - Load byte: rdata <= {8'b0, mem_rd[7:0]} (zero-extended).
  - Load word: rdata[15:8] <= mem_rd[7:0].
  - Next state: FIN.
- FIN: done=1 and err valid. Next state is always IDLE.
  - If req is still high in the following IDLE cycle, a new access is accepted.
- Outside B0/B1: mem_we=0, mem_a=0, mem_wd=0.
- Stores leave rdata unchanged.
- busy = req & ~done, forced 0 while reset is high.

## Timing
- Latency from the accept edge (IDLE with req) to the done cycle:
  - store byte: 2 cycles
  - store word: 3 cycles
  - load byte: 3 cycles
  - load word: 4 cycles
  - error: 1 cycle
- Back-to-back: one IDLE cycle between accesses is mandatory, so throughput is latency + 1 cycles.
- mem_we, mem_a and mem_wd are combinational from state and latched registers. A write commits on the clk edge ending B0/B1.
- Reset value of every output is 0: rdata, done, err, busy, mem_we, mem_a, mem_wd. State resets to IDLE.
- Reset mid-operation deasserts mem_we immediately, aborts the access and produces no done. A word store interrupted after B0 leaves byte 0 written and byte 1 unwritten.
- addr+1 never wraps across a segment boundary, because aligned word addresses have addr[0]=0.

## Test plan
- Store word 0xBEEF at 0x0010, then load word at 0x0010:
  - mem_we is high for 2 cycles, with mem_a=0x0010, mem_wd=0x00EF, then mem_a=0x0011, mem_wd=0x00BE.
  - The load gives rdata=0xBEEF with done 4 cycles after accept.
- Store byte 0x5A at 0x1FFF, then load byte at 0x1FFF: rdata=0x005A, store done at +2, load done at +3.
- Load word at 0x0011: done at +1 with err=1, rdata=0, mem_we never asserted.
- Load byte at 0x2000: err=1 (out of segment), no memory access.
- Hold req high across two loads (byte 0x0004, then word 0x0006):
  - exactly one IDLE cycle separates them;
  - busy is low only in each done cycle;
  - changes to addr mid-access have no effect.
- Assert reset in B1 of a word store to 0x0020 with data 0x1234:
  - all outputs go to 0 immediately;
  - memory at 0x0020 holds 0x34 and 0x0021 is unchanged;
  - the next request after reset completes normally.
